// File: rtl/fpu_issue_ctrl_if.sv
// Issue/return handshake bundle for fpu_issue_ctrl.
//   master : FP issue stage side (drives requests, consumes results)
//   slave  : fpu_issue_ctrl side
// Request  : in_valid, in_ready, in_op, in_a, in_b, in_tag
// Response : out_valid, out_ready, out_result, out_tag, out_op
// Optional : out_dz, present only when FPU_DIV_ZERO_FLAG_EN is defined
interface fpu_issue_ctrl_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       out_op;
`ifdef FPU_DIV_ZERO_FLAG_EN
  logic             out_dz;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_op, out_dz
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_op, out_dz
  );
`else
  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_op
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_op
  );
`endif
endinterface

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: in-order issue/return controller for fixed-latency
// add/sub, multiply and divide units.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   io (slave)     op request (valid/ready, op, a, b, tag) and result
//                  return (valid/ready, result, tag, op)
//   add_a/add_b/add_sub, mul_a/mul_b, div_n/div_d
//                  registered unit operands
//   add_res/mul_res/div_res
//                  unit results, valid L cycles after operands
//   busy           any op in flight or result queued
//
// Optional build macro FPU_DIV_ZERO_FLAG_EN adds io.out_dz: set for div ops
// whose divisor magnitude bits are zero.
//
// Ordering: each op is tagged with a token that shadows its unit pipeline.
// A drain counter tracks cycles until the latest in-flight completion; an op
// is only accepted if it finishes strictly after that, so completions land in
// issue order and never collide at the output FIFO.
module fpu_issue_ctrl #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned ADD_LAT   = 3,
  parameter int unsigned MUL_LAT   = 4,
  parameter int unsigned DIV_LAT   = 8,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  fpu_issue_ctrl_if.slave  io,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_sub,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic [WIDTH-1:0] div_n,
  output logic [WIDTH-1:0] div_d,
  input  logic [WIDTH-1:0] add_res,
  input  logic [WIDTH-1:0] mul_res,
  input  logic [WIDTH-1:0] div_res,
  output logic             busy
);

  localparam int unsigned MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int unsigned MAX_LAT = (MAX_AM > DIV_LAT) ? MAX_AM : DIV_LAT;
  localparam int unsigned LAT_W   = $clog2(MAX_LAT + 1);
  localparam int unsigned PTR_W   = $clog2(OUT_DEPTH);
  localparam int unsigned CNT_W   = $clog2(OUT_DEPTH + 1);

  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Token shadowing an op through its unit pipeline
  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [1:0]       op;
`ifdef FPU_DIV_ZERO_FLAG_EN
    logic             dz;
`endif
  } token_t;

  // Output FIFO entry
  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [TAG_W-1:0] tag;
    logic [1:0]       op;
`ifdef FPU_DIV_ZERO_FLAG_EN
    logic             dz;
`endif
  } entry_t;

  logic [LAT_W-1:0] lat_sel;
  logic [LAT_W-1:0] drain;
  logic [CNT_W-1:0] occ;
  logic [CNT_W-1:0] fifo_cnt;
  logic             ready;
  logic             accept;
  logic             is_add;
  logic             is_mul;
  logic             is_div;
  token_t           tok_add;
  token_t           tok_mul;
  token_t           tok_div;
  token_t           done_tok;
  logic [WIDTH-1:0] done_res;
  logic             push;
  logic             pop;
  logic             out_vld;
  entry_t           push_entry;
  entry_t           head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Element 0 holds the token launched with the operand registers; element
  // L lines up with the unit result.
  token_t [ADD_LAT:0] add_pipe;
  token_t [MUL_LAT:0] mul_pipe;
  token_t [DIV_LAT:0] div_pipe;

  entry_t fifo_mem [OUT_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Latency of the op currently offered
  always_comb begin
    lat_sel = LAT_W'(ADD_LAT);
    case (io.in_op)
      OP_MUL:  lat_sel = LAT_W'(MUL_LAT);
      OP_DIV:  lat_sel = LAT_W'(DIV_LAT);
      default: lat_sel = LAT_W'(ADD_LAT);
    endcase
  end

  // Credit counts tokens in flight plus queued results; a same-cycle pop
  // is deliberately not credited.
  assign ready       = reset & (lat_sel > drain) & (occ < CNT_W'(OUT_DEPTH));
  assign io.in_ready = ready;
  assign accept      = io.in_valid & ready;
  assign is_add      = accept & ~io.in_op[1];
  assign is_mul      = accept & (io.in_op == OP_MUL);
  assign is_div      = accept & (io.in_op == OP_DIV);

  // Per-unit launch tokens
  always_comb begin
    tok_add     = '0;
    tok_add.tag = io.in_tag;
    tok_add.op  = io.in_op;
`ifdef FPU_DIV_ZERO_FLAG_EN
    tok_add.dz  = (io.in_op == OP_DIV) && (io.in_b[WIDTH-2:0] == '0);
`endif
    tok_mul     = tok_add;
    tok_div     = tok_add;
    tok_add.vld = is_add;
    tok_mul.vld = is_mul;
    tok_div.vld = is_div;
  end

  // Operand registers: only the selected unit's inputs change
  always_ff @(posedge clk) begin
    if (!reset) begin
      add_a   <= '0;
      add_b   <= '0;
      add_sub <= 1'b0;
      mul_a   <= '0;
      mul_b   <= '0;
      div_n   <= '0;
      div_d   <= '0;
    end else begin
      if (is_add) begin
        add_a   <= io.in_a;
        add_b   <= io.in_b;
        add_sub <= io.in_op[0];
      end
      if (is_mul) begin
        mul_a <= io.in_a;
        mul_b <= io.in_b;
      end
      if (is_div) begin
        div_n <= io.in_a;
        div_d <= io.in_b;
      end
    end
  end

  // Cycles remaining until the latest in-flight completion
  always_ff @(posedge clk) begin
    if (!reset) begin
      drain <= '0;
    end else if (accept) begin
      drain <= lat_sel - LAT_W'(1);
    end else if (drain != '0) begin
      drain <= drain - LAT_W'(1);
    end
  end

  // Token delay lines
  always_ff @(posedge clk) begin
    if (!reset) begin
      add_pipe <= '0;
      mul_pipe <= '0;
      div_pipe <= '0;
    end else begin
      add_pipe <= {add_pipe[ADD_LAT-1:0], tok_add};
      mul_pipe <= {mul_pipe[MUL_LAT-1:0], tok_mul};
      div_pipe <= {div_pipe[DIV_LAT-1:0], tok_div};
    end
  end

  // Completing token; the drain rule guarantees at most one per cycle
  always_comb begin
    done_tok = '0;
    done_res = '0;
    if (add_pipe[ADD_LAT].vld) begin
      done_tok = add_pipe[ADD_LAT];
      done_res = add_res;
    end else if (mul_pipe[MUL_LAT].vld) begin
      done_tok = mul_pipe[MUL_LAT];
      done_res = mul_res;
    end else if (div_pipe[DIV_LAT].vld) begin
      done_tok = div_pipe[DIV_LAT];
      done_res = div_res;
    end
  end

  always_comb begin
    push           = done_tok.vld;
    push_entry     = '0;
    push_entry.res = done_res;
    push_entry.tag = done_tok.tag;
    push_entry.op  = done_tok.op;
`ifdef FPU_DIV_ZERO_FLAG_EN
    push_entry.dz  = done_tok.dz;
`endif
  end

  assign out_vld = reset & (fifo_cnt != '0);
  assign pop     = out_vld & io.out_ready;

  // Output FIFO control and occupancy (in flight + queued)
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      occ      <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      occ      <= occ + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  // FIFO storage; contents are masked whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_entry;
  end

  assign head          = fifo_mem[rd_ptr];
  assign io.out_valid  = out_vld;
  assign io.out_result = out_vld ? head.res : '0;
  assign io.out_tag    = out_vld ? head.tag : '0;
  assign io.out_op     = out_vld ? head.op  : 2'b00;
`ifdef FPU_DIV_ZERO_FLAG_EN
  assign io.out_dz     = out_vld & head.dz;
`endif

  assign busy = reset & (occ != '0);

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Parametrised successor to the current FPU wrapper: a handshaked issue/return controller for the fixed-latency add/sub, multiply and divide pipelines.
- Accepts one tagged op per cycle (valid/ready) and drives registered operands into the selected unit.
- Tracks in-flight ops with per-unit valid/tag delay lines and returns results strictly in issue order through an output FIFO with valid/ready backpressure.
- Sits between the core's FP issue stage and the arithmetic units; replaces the combinational op_mode result mux.

Parameters:
- WIDTH, 32, operand/result width.
- TAG_W, 4, width of the caller tag carried with each op.
- ADD_LAT, 3, add/sub unit latency in cycles (must be >= 1).
- MUL_LAT, 4, multiply unit latency (must be >= 1).
- DIV_LAT, 8, divide unit latency (must be >= 1).
- OUT_DEPTH, 4, output FIFO depth and in-flight credit limit (must be >= 2).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  op request valid
- in_ready  out  1  controller can accept an op this cycle
- in_op  in  2  00 add, 01 sub, 10 mul, 11 div
- in_a  in  WIDTH  operand a (dividend for div)
- in_b  in  WIDTH  operand b (divisor for div)
- in_tag  in  TAG_W  caller tag
- add_a, add_b  out  WIDTH  registered add/sub unit operands
- add_sub  out  1  0 add, 1 sub
- mul_a, mul_b  out  WIDTH  registered multiply operands
- div_n, div_d  out  WIDTH  registered divide operands (n=a, d=b)
- add_res, mul_res, div_res  in  WIDTH  unit results
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  result
- out_tag  out  TAG_W  tag of result
- out_op  out  2  op code of result
- busy  out  1  any op in flight or FIFO non-empty

Behaviour:
- Reset (reset==0 at an edge): all operand regs 0, add_sub 0, delay lines cleared, drain counter D=0, FIFO empty. in_ready, out_valid and busy are 0 during reset and 1/0/0 in the first cycle after release. out_result, out_tag and out_op are 0 while the FIFO is empty.
- Accept: an op is accepted in a cycle where in_valid & in_ready are both 1.
- Unit latency L means a value presented at unit inputs in cycle k appears at the unit result in cycle k+L.
- Issue (accept in cycle 0):
  - The selected unit's operand regs update at the end of cycle 0. Operand regs of other units hold their values.
  - A valid+tag+op token enters that unit's L-stage delay line.
  - In cycle 1+L the unit result is written into the FIFO together with the token tag and op.
  - out_valid rises in cycle 2+L if the FIFO was empty.
- Ordering/collision rule:
  - D counts cycles until the latest in-flight completion.
  - An op with latency L is accepted only if L > D.
  - On accept, D <= L-1; otherwise D <= max(D-1,0).
  - This guarantees strictly in-order, at most one FIFO write per cycle.
- Credit: in_ready = reset & (L_sel > D) & (inflight + fifo_count < OUT_DEPTH).
  - L_sel is the latency of the op on in_op.
  - A same-cycle FIFO pop does not add credit.
  - in_ready may depend combinationally on in_op; in_valid must not depend on in_ready.
- FIFO: standard synchronous FIFO; out_* show the head entry.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop is legal at any occupancy, including full.
  - Overflow is impossible by credit.
- Sub: routed to the add unit with add_sub=1; add_sub is registered alongside operands.
- busy = (any delay-line valid) | (fifo_count != 0).
- Reset mid-operation: all tokens and FIFO contents are discarded. Unit outputs are ignored until new tokens arrive; no stale result ever appears at out_*.

Optional Feature:
- Macro FPU_DIV_ZERO_FLAG_EN.
- When defined: adds output out_dz (1 bit). It is set for div ops whose in_b[WIDTH-2:0]==0, carried through the token and FIFO, and is 0 for all other ops and in reset.
- When undefined: the port and its storage are absent; all other behaviour is identical.

Test Plan:
- Single add, in_a=0x3F800000, in_b=0x40000000, op 00, tag 5, out_ready=1 (behavioural unit models) -> out_result 0x40400000, out_tag 5, out_valid in cycle 2+ADD_LAT=5 after accept.
- Back-to-back div (tag 1) then add (tag 2) -> add stalled (in_ready=0) while D>=ADD_LAT. Results are returned tag 1 then tag 2, never reordered.
- Hold out_ready=0 and issue 6 mul ops -> exactly OUT_DEPTH=4 accepted, in_ready=0 thereafter. Releasing out_ready drains 4 results in order, then acceptance resumes.
- Sub 0x40400000 - 0x3F800000 -> add_sub=1 at the unit, out_result 0x40000000, out_op 01.
- Issue div and mul, assert reset low for one cycle mid-flight -> no out_valid for those ops; busy=0 after release; a new add completes normally.
- With FPU_DIV_ZERO_FLAG_EN, div 0x3F800000 / 0x80000000 -> out_dz=1. A div by 0x40000000 -> out_dz=0.
